sd_sector_cache: RTL and testbench
==================================

# sd_sector_cache

Sector buffer directly downstream of the SD card reader. Captures the 16-bit words the reader emits on its cache-write port (address, value, write strobe), tracks sector fill, and serves the completed sector to the processor through a request/valid read port. A release input frees the buffer for the next sector transfer.

## Interface
- DEPTH, 256, words per sector; fill completes after DEPTH writes
- AW, 8, address width, log2(DEPTH)
- DW, 16, data word width

- clk400  in  1  sole clock, same 400 kHz domain as the reader
- reset_n  in  1  asynchronous, active-low reset
- casheAddress  in  AW  write address from reader
- casheValue  in  DW  write data from reader
- writeCashe  in  1  write strobe, one word per high cycle
- release  in  1  processor frees buffer / aborts fill
- rdReq  in  1  read request, single cycle
- rdAddr  in  AW  read address, sampled with rdReq
- rdData  out  DW  read data, valid with rdValid
- rdValid  out  1  one-cycle pulse answering each rdReq
- rdErr  out  1  qualifies rdValid: request made outside READY
- sectorReady  out  1  high while state is READY
- overflow  out  1  sticky: write arrived while READY
- fillCount  out  AW+1  words accepted this sector, 0..DEPTH
- checksum  out  DW  only with SD_CACHE_CHECKSUM_EN (see Configuration)

## Operation
- States: EMPTY, FILLING, READY. Reset -> EMPTY.
- EMPTY: writeCashe stores word, fillCount <= 1, -> FILLING. release ignored.
- FILLING: each writeCashe stores word, fillCount += 1; write bringing fillCount to DEPTH -> READY. release: fillCount <= 0, -> EMPTY; write in same cycle dropped (release wins).
- Fill counts strobes, not distinct addresses; repeated address overwrites and still counts.
- READY: writes dropped, RAM unchanged, overflow <= 1. release -> EMPTY, fillCount <= 0, overflow <= 0.
- Read: rdReq in READY -> next cycle rdValid=1, rdErr=0, rdData=mem[rdAddr]. rdReq in EMPTY/FILLING -> next cycle rdValid=1, rdErr=1, rdData=0.
- rdReq + release same cycle in READY: read served normally (rdErr=0), state -> EMPTY.
- rdReq accepted every cycle; back-to-back requests give back-to-back rdValid.
- RAM contents not cleared by reset or release; only fillCount/state gate access.

## Timing
- Reset values: sectorReady 0, rdValid 0, rdErr 0, rdData 0, overflow 0, fillCount 0, checksum 0; state EMPTY.
- Write: RAM updated on clk400 edge sampling writeCashe; fillCount updates same edge.
- sectorReady rises the cycle after the DEPTH-th write edge; falls the cycle after release sampled.
- Read latency exactly 1 cycle; rdValid/rdErr/rdData registered; rdData holds last value when rdValid=0.
- reset_n asserted mid-fill or mid-read: immediate return to reset values; pending rdValid suppressed.

## Configuration
- SD_CACHE_CHECKSUM_EN defined: checksum port present; checksum = modulo-2^DW sum of every accepted word this sector; cleared on reset and release; frozen in READY.
- Undefined: checksum port and adder absent; all other behaviour identical.

## Structure
- Package sd_cache_pkg: state enum (EMPTY, FILLING, READY), SD_DEPTH=256, SD_AW=8, SD_DW=16.
- One sub-module: sd_cache_ram, DEPTH x DW simple dual-port RAM, one synchronous write port, one registered read port.
- FSM, fill counter, read response and checksum in top level.

## Test plan
- Reset then 256 writes, value = address ^ 16'hA5A5 -> sectorReady=1 one cycle after 256th write, fillCount=256; rdReq rdAddr=8'h10 -> next cycle rdData=16'hA5B5, rdValid=1, rdErr=0.
- rdReq in FILLING after 10 writes -> rdValid=1, rdErr=1, rdData=0; fillCount stays 10.
- Write while READY, addr 0 value 16'hFFFF -> overflow=1, read addr 0 still 16'hA5A5; release -> overflow=0, fillCount=0, sectorReady=0.
- release with writeCashe same cycle at fillCount=100 -> state EMPTY, fillCount=0, write dropped.
- reset_n low at fillCount=200 -> all outputs reset values; refill 256 words reaches READY normally.
- With SD_CACHE_CHECKSUM_EN: 256 writes of 16'h0101 -> checksum=16'h0100; release -> checksum=0.

Source files
------------

// File: rtl/sd_cache_pkg.sv
// Shared types and sizing for the SD sector cache.
// Optional build macro SD_CACHE_CHECKSUM_EN is consumed by sd_sector_cache.
package sd_cache_pkg;
    localparam int SD_DEPTH = 256;
    localparam int SD_AW    = 8;
    localparam int SD_DW    = 16;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2
    } cache_state_t;
endpackage

// File: rtl/sd_cache_ram.sv
// Simple dual-port sector RAM: synchronous write, registered read with enable.
// The read register holds its value between enabled reads.
module sd_cache_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          clk400,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Storage is never reset; only the cache FSM gates what is visible.
    always_ff @(posedge clk400) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk400 or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/sd_sector_cache.sv
// Sector buffer between the SD reader and the processor: fill FSM, read port, overflow flag.
// Define SD_CACHE_CHECKSUM_EN to add the running per-sector checksum output.
module sd_sector_cache
    import sd_cache_pkg::*;
#(
    parameter int DEPTH = SD_DEPTH,
    parameter int AW    = SD_AW,
    parameter int DW    = SD_DW
) (
    input  logic          clk400,
    input  logic          reset_n,
    input  logic [AW-1:0] casheAddress,
    input  logic [DW-1:0] casheValue,
    input  logic          writeCashe,
    // "release" is a reserved word in SystemVerilog, hence the longer name.
    input  logic          releaseSector,
    input  logic          rdReq,
    input  logic [AW-1:0] rdAddr,
    output logic [DW-1:0] rdData,
    output logic          rdValid,
    output logic          rdErr,
    output logic          sectorReady,
    output logic          overflow,
    output logic [AW:0]   fillCount,
`ifdef SD_CACHE_CHECKSUM_EN
    output logic [DW-1:0] checksum,
`endif
    output cache_state_t  cacheState
);
    // Read handshake: rdReq is a single-cycle request accepted every cycle;
    // exactly one cycle later rdValid pulses, with rdErr set when the request
    // was made outside READY (rdData is then forced to zero).
    cache_state_t  state;
    logic          wr_accept;
    logic          rd_hit;
    logic          zero_data;
    logic [DW-1:0] ram_q;

    always_comb begin
        wr_accept = 1'b0;
        if (writeCashe) begin
            wr_accept = (state == EMPTY) || ((state == FILLING) && !releaseSector);
        end
        rd_hit = rdReq && (state == READY);
    end

    sd_cache_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk400  (clk400),
        .reset_n (reset_n),
        .we      (wr_accept),
        .waddr   (casheAddress),
        .wdata   (casheValue),
        .re      (rd_hit),
        .raddr   (rdAddr),
        .rdata   (ram_q)
    );

    always_ff @(posedge clk400 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= EMPTY;
            sectorReady <= 1'b0;
            overflow    <= 1'b0;
            fillCount   <= '0;
            rdValid     <= 1'b0;
            rdErr       <= 1'b0;
            zero_data   <= 1'b0;
        end else begin
            rdValid <= rdReq;
            rdErr   <= rdReq && (state != READY);
            if (rdReq) begin
                zero_data <= (state != READY);
            end
            case (state)
                EMPTY: begin
                    if (writeCashe) begin
                        fillCount <= {{AW{1'b0}}, 1'b1};
                        state     <= FILLING;
                    end
                end
                FILLING: begin
                    if (releaseSector) begin
                        fillCount <= '0;
                        state     <= EMPTY;
                    end else if (writeCashe) begin
                        fillCount <= fillCount + 1'b1;
                        if (fillCount == (AW+1)'(DEPTH - 1)) begin
                            state       <= READY;
                            sectorReady <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (releaseSector) begin
                        fillCount   <= '0;
                        overflow    <= 1'b0;
                        sectorReady <= 1'b0;
                        state       <= EMPTY;
                    end else if (writeCashe) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    sectorReady <= 1'b0;
                end
            endcase
        end
    end

`ifdef SD_CACHE_CHECKSUM_EN
    always_ff @(posedge clk400 or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (releaseSector && (state != EMPTY)) begin
            checksum <= '0;
        end else if (wr_accept) begin
            checksum <= checksum + casheValue;
        end
    end
`endif

    assign rdData     = zero_data ? '0 : ram_q;
    assign cacheState = state;
endmodule

// File: tb/tb_sd_sector_cache.sv
// Self-checking bench for sd_sector_cache: vector table, directed sequences, read scoreboard.
// Build with SD_CACHE_CHECKSUM_EN to also exercise the checksum output.
module tb_sd_sector_cache;
    import sd_cache_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk400;
    logic          reset_n;
    logic [AW-1:0] casheAddress;
    logic [DW-1:0] casheValue;
    logic          writeCashe;
    logic          releaseSector;
    logic          rdReq;
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] rdData;
    logic          rdValid;
    logic          rdErr;
    logic          sectorReady;
    logic          overflow;
    logic [AW:0]   fillCount;
    cache_state_t  cacheState;
`ifdef SD_CACHE_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int checks = 0;
    int fails  = 0;
    logic [DW:0] exp_q[$];

    sd_sector_cache dut (
        .clk400        (clk400),
        .reset_n       (reset_n),
        .casheAddress  (casheAddress),
        .casheValue    (casheValue),
        .writeCashe    (writeCashe),
        .releaseSector (releaseSector),
        .rdReq         (rdReq),
        .rdAddr        (rdAddr),
        .rdData        (rdData),
        .rdValid       (rdValid),
        .rdErr         (rdErr),
        .sectorReady   (sectorReady),
        .overflow      (overflow),
        .fillCount     (fillCount),
`ifdef SD_CACHE_CHECKSUM_EN
        .checksum      (checksum),
`endif
        .cacheState    (cacheState)
    );

    // clock / reset
    initial clk400 = 1'b0;
    always #5 clk400 = ~clk400;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {8'h00, a} ^ 16'hA5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: inputs applied at a falling edge, held across one rising edge
    task automatic step(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] v,
                        input logic rel, input logic rd, input logic [AW-1:0] ra);
        writeCashe    = we;
        casheAddress  = a;
        casheValue    = v;
        releaseSector = rel;
        rdReq         = rd;
        rdAddr        = ra;
        @(negedge clk400);
        writeCashe    = 1'b0;
        releaseSector = 1'b0;
        rdReq         = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
        step(1'b1, a, v, 1'b0, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] ra, input logic exp_err, input logic [DW-1:0] exp_data);
        exp_q.push_back({exp_err, exp_data});
        step(1'b0, '0, '0, 1'b0, 1'b1, ra);
    endtask

    task automatic rel_only();
        step(1'b0, '0, '0, 1'b1, 1'b0, '0);
    endtask

    // scoreboard: every rdValid pulse consumes one expected response
    always @(negedge clk400) begin
        logic [DW:0] e;
        if (reset_n && rdValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL rd_unexpected: got rdValid=1 expected no response");
            end else begin
                e = exp_q.pop_front();
                check("rd_err", 32'(rdErr), 32'(e[DW]));
                check("rd_data", 32'(rdData), 32'(e[DW-1:0]));
            end
        end
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        logic          rel;
        logic          rd;
        logic [AW-1:0] ra;
        logic          exp_err;
        logic [DW-1:0] exp_data;
        logic [AW:0]   exp_fill;
        logic          exp_ready;
        logic          exp_ovf;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [AW-1:0] ra;

        tbl[0] = '{1'b1, 8'h00, 16'hFFFF, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 9'd256, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h00, 1'b0, 16'hA5A5, 9'd256, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h20, 1'b0, 16'hA585, 9'd0,   1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h20, 1'b1, 16'h0000, 9'd0,   1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h03, 16'h1234, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 9'd1,   1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 9'd0,   1'b0, 1'b0};

        reset_n = 1'b0;
        writeCashe = 1'b0; releaseSector = 1'b0; rdReq = 1'b0;
        casheAddress = '0; casheValue = '0; rdAddr = '0;
        repeat (3) @(negedge clk400);
        reset_n = 1'b1;
        @(negedge clk400);
        check("rst_fill", 32'(fillCount), 0);
        check("rst_ready", 32'(sectorReady), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_rdvalid", 32'(rdValid), 0);
        check("rst_rderr", 32'(rdErr), 0);
        check("rst_rddata", 32'(rdData), 0);
        check("rst_state", 32'(cacheState), 32'(EMPTY));

        // partial fill, then a read while FILLING must error
        for (int i = 0; i < 10; i++) wr(8'(i), pat(8'(i)));
        check("fill10", 32'(fillCount), 10);
        rd(8'h05, 1'b1, 16'h0000);
        check("fill10_after_rd", 32'(fillCount), 10);
        check("fill10_ready", 32'(sectorReady), 0);

        for (int i = 10; i < 255; i++) wr(8'(i), pat(8'(i)));
        check("fill255", 32'(fillCount), 255);
        check("fill255_ready", 32'(sectorReady), 0);
        wr(8'hFF, pat(8'hFF));
        check("fill256", 32'(fillCount), 256);
        check("fill256_ready", 32'(sectorReady), 1);

        rd(8'h10, 1'b0, 16'hA5B5);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0);
        check("rddata_hold", 32'(rdData), 32'h0000A5B5);
        check("rdvalid_idle", 32'(rdValid), 0);

        // back-to-back random reads
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rd(ra, 1'b0, pat(ra));
        end

        // READY corner cases: overflow, read+release, EMPTY release ignored
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].rd) exp_q.push_back({tbl[i].exp_err, tbl[i].exp_data});
            step(tbl[i].we, tbl[i].a, tbl[i].v, tbl[i].rel, tbl[i].rd, tbl[i].ra);
            check($sformatf("vec%0d_fill", i), 32'(fillCount), 32'(tbl[i].exp_fill));
            check($sformatf("vec%0d_ready", i), 32'(sectorReady), 32'(tbl[i].exp_ready));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].exp_ovf));
        end

        // release wins over a same-cycle write at fillCount=100
        for (int i = 0; i < 100; i++) wr(8'(i), pat(8'(i)));
        check("fill100", 32'(fillCount), 100);
        step(1'b1, 8'h00, 16'hDEAD, 1'b1, 1'b0, '0);
        check("relwr_fill", 32'(fillCount), 0);
        check("relwr_ready", 32'(sectorReady), 0);
        check("relwr_state", 32'(cacheState), 32'(EMPTY));
        // refill skipping address 0; address 255 written twice still counts
        for (int i = 1; i < 256; i++) wr(8'(i), pat(8'(i)));
        check("refill255", 32'(fillCount), 255);
        wr(8'hFF, pat(8'hFF));
        check("refill_ready", 32'(sectorReady), 1);
        rd(8'h00, 1'b0, 16'hA5A5);
        rd(8'hFF, 1'b0, 16'hA55A);

        // asynchronous reset mid-fill with a read in flight
        rel_only();
        for (int i = 0; i < 200; i++) wr(8'(i), pat(8'(i)));
        check("fill200", 32'(fillCount), 200);
        rdReq = 1'b1;
        @(posedge clk400);
        #1;
        reset_n = 1'b0;
        rdReq   = 1'b0;
        @(negedge clk400);
        check("midrst_fill", 32'(fillCount), 0);
        check("midrst_ready", 32'(sectorReady), 0);
        check("midrst_rdvalid", 32'(rdValid), 0);
        check("midrst_rderr", 32'(rdErr), 0);
        check("midrst_rddata", 32'(rdData), 0);
        check("midrst_state", 32'(cacheState), 32'(EMPTY));
        reset_n = 1'b1;
        @(negedge clk400);
        for (int i = 0; i < 256; i++) wr(8'(i), pat(8'(i)));
        check("postrst_fill", 32'(fillCount), 256);
        check("postrst_ready", 32'(sectorReady), 1);
        rd(8'h07, 1'b0, pat(8'h07));

`ifdef SD_CACHE_CHECKSUM_EN
        rel_only();
        check("csum_cleared", 32'(checksum), 0);
        for (int i = 0; i < 256; i++) wr(8'(i), 16'h0101);
        check("csum_full", 32'(checksum), 32'h0100);
        wr(8'h00, 16'h1111);
        check("csum_frozen", 32'(checksum), 32'h0100);
        rel_only();
        check("csum_release", 32'(checksum), 0);
`endif

        repeat (3) @(negedge clk400);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
